// File: rtl/rf_pkg.sv
// Shared constants and packed-port helpers for the multi-port register file
// and its busy-bit scoreboard.
package rf_pkg;

  localparam int   RF_WIDTH_DEF      = 32;
  localparam int   RF_ADDR_W_DEF     = 5;
  localparam int   RF_ADDR_ZERO      = 0;
  localparam logic RF_WRITE_ENABLED  = 1'b1;
  localparam logic RF_WRITE_DISABLED = 1'b0;

  // Lowest bit of port `port` inside a packed bus of `w`-bit fields.
  function automatic int port_lsb(input int port, input int w);
    return port * w;
  endfunction

  // Total width of a packed bus holding `nr` fields of `w` bits.
  function automatic int bus_width(input int nr, input int w);
    return nr * w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue, cleared on
// writeback; an issue in the same cycle as a writeback wins.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int NR_WR  = 2,
  parameter int ADDR_W = RF_ADDR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NR_WR-1:0]        wr_en,
  input  logic [NR_WR*ADDR_W-1:0] wr_addr,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic [DEPTH-1:0]        busy_vec
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic [DEPTH-1:0] busy_d;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_en) set_vec[iss_addr] = 1'b1;
    for (int j = 0; j < NR_WR; j++) begin
      if (wr_en[j] == RF_WRITE_ENABLED)
        clr_vec[wr_addr[port_lsb(j, ADDR_W) +: ADDR_W]] = 1'b1;
    end
    // A fresh issue means a newer producer is in flight, so set beats clear.
    busy_d = (busy_q & ~clr_vec) | set_vec;
    busy_d[RF_ADDR_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/rf_mp_sb.sv
// Multi-port register file (NR_RD comb reads, NR_WR prioritised writes, r0 = 0)
// with busy scoreboard. Define RF_BYPASS_EN for same-cycle write-to-read bypass.
module rf_mp_sb
  import rf_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH_DEF,
  parameter int ADDR_W = RF_ADDR_W_DEF,
  parameter int NR_RD  = 2,
  parameter int NR_WR  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NR_RD*ADDR_W-1:0] rd_addr,
  output logic [NR_RD*WIDTH-1:0]  rd_data,
  output logic [NR_RD-1:0]        rd_busy,
  input  logic [NR_WR-1:0]        wr_en,
  input  logic [NR_WR*ADDR_W-1:0] wr_addr,
  input  logic [NR_WR*WIDTH-1:0]  wr_data,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_addr,
  output logic [2**ADDR_W-1:0]    busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0]  regs   [DEPTH];
  logic [DEPTH-1:0]  wr_hit;
  logic [WIDTH-1:0]  wr_val [DEPTH];
  logic [ADDR_W-1:0] wa;
  logic [ADDR_W-1:0] ra;

  // Per-address write select; walking ports high-to-low lets port 0 win.
  always_comb begin
    wa     = '0;
    wr_hit = '0;
    for (int a = 0; a < DEPTH; a++) wr_val[a] = '0;
    for (int j = NR_WR - 1; j >= 0; j--) begin
      wa = wr_addr[port_lsb(j, ADDR_W) +: ADDR_W];
      if (wr_en[j] == RF_WRITE_ENABLED && wa != ADDR_W'(RF_ADDR_ZERO)) begin
        wr_hit[wa] = 1'b1;
        wr_val[wa] = wr_data[port_lsb(j, WIDTH) +: WIDTH];
      end
    end
  end

  // Entry 0 is reset and never written, so it folds to a constant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < DEPTH; a++) regs[a] <= '0;
    end else begin
      for (int a = 1; a < DEPTH; a++) begin
        if (wr_hit[a]) regs[a] <= wr_val[a];
      end
    end
  end

  always_comb begin
    ra      = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NR_RD; i++) begin
      ra = rd_addr[port_lsb(i, ADDR_W) +: ADDR_W];
      if (ra != ADDR_W'(RF_ADDR_ZERO)) begin
        rd_data[port_lsb(i, WIDTH) +: WIDTH] = regs[ra];
        rd_busy[i] = busy_vec[ra];
`ifdef RF_BYPASS_EN
        if (wr_hit[ra] && !rst) begin
          rd_data[port_lsb(i, WIDTH) +: WIDTH] = wr_val[ra];
          rd_busy[i] = iss_en && (iss_addr == ra);
        end
`endif
      end
    end
  end

  rf_scoreboard #(
    .DEPTH  (DEPTH),
    .NR_WR  (NR_WR),
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec)
  );

endmodule

// File: doc/rf_mp_sb.md
Name: rf_mp_sb

Overview:
- Parametrised multi-port register file with an integrated busy-bit scoreboard, for the pipelined datapath.
- Provides NR_RD combinational read ports and NR_WR synchronous write ports. Register 0 reads as zero.
- The scoreboard marks registers with an in-flight producer so the hazard unit can stall or forward.
- Replaces the single-issue 2R1W register file in the multi-issue core.

Parameters:
- WIDTH, 32: data width of each register, in bits.
- ADDR_W, 5: address width. DEPTH = 2**ADDR_W registers.
- NR_RD, 2: number of read ports, 1..8.
- NR_WR, 2: number of write ports, 1..4. A lower index has higher priority.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NR_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NR_RD*WIDTH  packed read data, combinational.
- rd_busy  out  NR_RD  busy bit of each read address, combinational.
- wr_en  in  NR_WR  per-port write enable.
- wr_addr  in  NR_WR*ADDR_W  packed write addresses.
- wr_data  in  NR_WR*WIDTH  packed write data.
- iss_en  in  1  issue strobe; marks iss_addr busy.
- iss_addr  in  ADDR_W  destination register of the issuing instruction.
- busy_vec  out  DEPTH  full scoreboard; bit 0 is always 0.

Behaviour:
- Reset: asynchronous and active-high.
  - While rst=1, all registers 1..DEPTH-1 are 0 and all busy bits are 0, independent of clk.
  - Consequently rd_data=0 for every port and rd_busy=0, busy_vec=0.
  - Writes and issues presented while rst=1 are discarded.
  - Deassertion is synchronised externally; the first edge after deassertion is a normal cycle.
- Register 0:
  - Never stored; reads return 0 and rd_busy=0.
  - Writes to address 0 are ignored.
  - iss_en with iss_addr=0 sets nothing.
- Reads:
  - rd_data[i] = reg[rd_addr[i]], with zero latency and no clock involved.
  - Without bypass, a value written at edge N is visible after edge N.
- Writes:
  - Each port j with wr_en[j]=1 and a nonzero address updates reg[wr_addr[j]] at the rising edge.
  - When several ports target the same address in one cycle, the lowest j wins. Higher ports to that address are dropped; no error is raised.
- Scoreboard, per address a≠0, at each edge:
  - If iss_en=1 and iss_addr=a: busy[a] becomes 1. Set beats clear when a write to a occurs in the same cycle, because a newer producer has been issued.
  - Else if any enabled write port targets a: busy[a] becomes 0.
  - Otherwise busy[a] holds.
- Issuing to an address that is already busy is legal; the bit stays 1, with no count kept (one outstanding producer per register, enforced by the hazard unit).
- Writes clear busy even if the register was never issued.
- rd_busy[i] = busy[rd_addr[i]]; busy_vec drives all busy bits directly.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - A read whose address matches an enabled, nonzero write address in the same cycle returns that port's wr_data, using the same lowest-j priority.
  - rd_busy for that read is 0, unless iss_en targets the same address in that cycle.
  - Adds one comparator set per read×write pair.
- Undefined:
  - Reads return stored contents only.
  - rd_busy reflects stored busy bits only.
  - Same-cycle write data is not visible until after the edge.

Decomposition:
- Package rf_pkg holds:
  - RF_ADDR_ZERO.
  - RF_WRITE_ENABLED / RF_WRITE_DISABLED.
  - Default WIDTH/ADDR_W constants.
  - Helper functions for packed-port slicing.
- Sub-module rf_scoreboard (DEPTH, NR_WR, ADDR_W) holds:
  - The busy vector with its async reset.
  - The set/clear priority logic.
  - Outputs: busy_vec.
- The top level holds:
  - The register array.
  - The write priority mux.
  - The read/bypass muxes.

Test Plan:
- Reset: load r5=0xDEADBEEF and busy[5]=1, assert rst mid-cycle (between edges) → rd_data and rd_busy read 0 immediately, before the next edge, and busy_vec=0.
- Basic write and read: wr_en[0] with r3=0x12345678 → read port 1 sees 0x12345678 after the edge. Write r0=0xFFFFFFFF → read r0 returns 0.
- Write conflict: ports 0 and 1 both write r7, 0xAAAA0000 and 0x0000BBBB → r7 holds 0xAAAA0000.
- Scoreboard: issue r9 → busy[9]=1 next cycle. Write r9 → busy[9]=0. Issue r9 and write r9 in the same cycle → busy[9]=1. Issue r0 → busy_vec unchanged.
- Bypass, built with RF_BYPASS_EN: read r4 while writing r4=0x55 → rd_data=0x55 in the same cycle, rd_busy=0. Without RF_BYPASS_EN → old r4 value until after the edge.
- Parameter sweep: NR_RD=4, NR_WR=1, WIDTH=64, ADDR_W=3 → randomised writes and issues match the reference model over 10k cycles.
